sram_arbiter: RTL

Two-port arbiter and timing sequencer for the 512 KB external asynchronous SRAM. It shares the SRAM between the Z80 memory path (CPU port) and a block-transfer engine (DMA port, e.g. SD-card sector moves). It generates CE/OE/WE strobes with a parameterised access width and a registered read-data return. The bidirectional data pin is resolved at top level using sram_dout and sram_drv.

---
 rtl/sram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Two-port (CPU/DMA) arbiter and CE/OE/WE timing sequencer for an
//             external asynchronous SRAM, with registered strobes and data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int ACC_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_drv,
  input  logic [7:0]        sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] C_ACC_LOAD = 4'(ACC_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last_dma;
  logic        r_sel_dma;
  logic        r_we;

  logic              w_any_req;
  logic              w_grant_dma;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;

  // Round-robin: DMA wins only when alone or when the CPU was served last.
  assign w_any_req   = cpu_req | dma_req;
  assign w_grant_dma = dma_req & (~cpu_req | ~r_last_dma);
  assign w_we        = w_grant_dma ? dma_we    : cpu_we;
  assign w_addr      = w_grant_dma ? dma_addr  : cpu_addr;
  assign w_wdata     = w_grant_dma ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_dma <= 1'b1;
      r_sel_dma  <= 1'b0;
      r_we       <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= 8'h00;
      sram_drv   <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
      dma_rdata  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel_dma  <= w_grant_dma;
            r_last_dma <= w_grant_dma;
            r_we       <= w_we;
            sram_addr  <= w_addr;
            sram_dout  <= w_wdata;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= w_we;
            sram_drv   <= w_we;
            busy       <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          r_cnt     <= C_ACC_LOAD;
          sram_we_n <= ~r_we;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            // Edge ending the last strobe cycle: close WE/OE, sample read data.
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (r_sel_dma) begin
              dma_ack <= 1'b1;
              if (!r_we) dma_rdata <= sram_din;
            end else begin
              cpu_ack <= 1'b1;
              if (!r_we) cpu_rdata <= sram_din;
            end
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          sram_ce_n <= 1'b1;
          sram_drv  <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
